seq_divider: RTL and testbench



---
 rtl/seq_divider.sv | 130 +++++++++++++
 tb/tb_seq_divider.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Iterative restoring divider: one quotient bit per clock from a single WIDTH+1-bit
// trial subtractor, with sign fix-up and a valid/ready result handshake.
module seq_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, BUSY, FIXUP, DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  quo_q, quo_d;
  logic [WIDTH-1:0]  remo_q, remo_d;
  logic              dbz_q, dbz_d;

  logic [WIDTH-1:0]  prem_q, prem_d;
  logic [WIDTH-1:0]  pquo_q, pquo_d;
  logic [WIDTH-1:0]  dvs_q, dvs_d;
  logic              negq_q, negq_d;
  logic              negr_q, negr_d;

  logic [WIDTH:0]        rem_sh;
  logic signed [WIDTH:0] trial;

  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic en);
    return en ? (~v + ONE) : v;
  endfunction

  // rem_sh < 2*divisor, so a non-negative difference always fits below bit WIDTH
  always_comb begin
    rem_sh = {prem_q, pquo_q[WIDTH-1]};
    trial  = signed'(rem_sh - {1'b0, dvs_q});
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    remo_d  = remo_q;
    dbz_d   = dbz_q;
    prem_d  = prem_q;
    pquo_d  = pquo_q;
    dvs_d   = dvs_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          dvs_d  = neg_if(divisor, is_signed & divisor[WIDTH-1]);
          pquo_d = neg_if(dividend, is_signed & dividend[WIDTH-1]);
          prem_d = '0;
          cnt_d  = CW'(WIDTH - 1);
          negq_d = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          negr_d = is_signed & dividend[WIDTH-1];
          if (divisor == '0) begin
            quo_d   = '1;
            remo_d  = dividend;
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        prem_d = (trial < 0) ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
        pquo_d = {pquo_q[WIDTH-2:0], ~trial[WIDTH]};
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == '0) state_d = FIXUP;
      end
      FIXUP: begin
        quo_d   = neg_if(pquo_q, negq_q);
        remo_d  = neg_if(prem_q, negr_q);
        dbz_d   = 1'b0;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      quo_q   <= '0;
      remo_q  <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      remo_q  <= remo_d;
      dbz_q   <= dbz_d;
    end
  end

  // Working datapath is always reloaded on accept, so it carries no reset
  always_ff @(posedge clk) begin
    prem_q <= prem_d;
    pquo_q <= pquo_d;
    dvs_q  <= dvs_d;
    negq_q <= negq_d;
    negr_q <= negr_d;
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = quo_q;
  assign remainder   = remo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed corner cases plus random operands
// checked against a plain-arithmetic reference model.
module tb_seq_divider;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         is_signed = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_cmp = 0;
  int n_bad = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .quotient(quotient),
    .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Reference: language-level truncating division; % takes the dividend's sign
  function automatic void model(input bit s, input bit [W-1:0] a, input bit [W-1:0] b,
                                output bit [W-1:0] q, output bit [W-1:0] r, output bit z);
    longint sa, sb;
    if (b == 0) begin
      q = '1; r = a; z = 1'b1;
    end else begin
      z = 1'b0;
      if (s) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
      end else begin
        sa = longint'(a);
        sb = longint'(b);
      end
      q = W'(sa / sb);
      r = W'(sa % sb);
    end
  endfunction

  task automatic run_div(input bit s, input bit [W-1:0] a, input bit [W-1:0] b,
                         input int stall, input bit poke);
    bit [W-1:0] eq, er;
    bit         ez;
    int         lat;
    model(s, a, b, eq, er, ez);
    @(negedge clk);
    chk("in_ready_before", in_ready, 1);
    start = 1'b1; is_signed = s; dividend = a; divisor = b;
    out_ready = (stall == 0);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!out_valid && lat < W + 5) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, ez ? 0 : W + 1);
    chk("quotient", quotient, eq);
    chk("remainder", remainder, er);
    chk("div_by_zero", div_by_zero, ez);
    for (int i = 0; i < stall; i++) begin
      if (poke && i == 1) begin
        start = 1'b1; is_signed = 1'b0; dividend = 16'h00FF; divisor = 16'h0003;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_quotient", quotient, eq);
      chk("hold_remainder", remainder, er);
      chk("hold_dbz", div_by_zero, ez);
    end
    start = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("valid_drop", out_valid, 0);
    chk("back_idle", in_ready, 1);
    chk("keep_quotient", quotient, eq);
    chk("keep_remainder", remainder, er);
    if (poke) begin
      @(negedge clk);
      chk("poke_ignored", in_ready, 1);
    end
  endtask

  initial begin
    bit [W-1:0] a, b;
    bit         s;

    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_div(1'b0, 16'd100, 16'd7, 0, 1'b0);
    run_div(1'b1, 16'hFFF9, 16'h0002, 0, 1'b0);
    run_div(1'b1, 16'h0007, 16'hFFFE, 0, 1'b0);
    run_div(1'b0, 16'hFFF9, 16'h0002, 0, 1'b0);
    run_div(1'b0, 16'h1234, 16'h0000, 0, 1'b0);
    run_div(1'b1, 16'h8000, 16'hFFFF, 0, 1'b0);
    run_div(1'b0, 16'hFFFF, 16'hFFFF, 0, 1'b0);
    run_div(1'b0, 16'hFFFE, 16'hFFFF, 0, 1'b0);
    run_div(1'b1, 16'h8000, 16'h0000, 0, 1'b0);
    run_div(1'b0, 16'd1000, 16'd7, 5, 1'b1);

    // Asynchronous reset landing mid-divide, between edges 8 and 9
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; dividend = 16'd1000; divisor = 16'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_quotient", quotient, 0);
    chk("midrst_remainder", remainder, 0);
    chk("midrst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    run_div(1'b0, 16'd9, 16'd3, 0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      s = 1'($urandom_range(0, 1));
      a = W'($urandom);
      case ($urandom_range(0, 9))
        0:       b = '0;
        1, 2, 3: b = W'($urandom_range(1, 20));
        4:       b = s ? 16'hFFFF : W'($urandom);
        default: b = W'($urandom);
      endcase
      run_div(s, a, b, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
